mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32, meaning data-memory address width (>=8).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning max WAIT cycles before bus error (1..255).
REQ-003 SHALL have parameter BIG_END, default 0, meaning byte-lane order (0 little, 1 big endian).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ex_valid in 1, ex_op in 6, ex_addr in AW, ex_wdata in 32, ex_result in 32, ex_rd in 5, ex_regwr in 1: EX-stage instruction.
REQ-007 SHALL have port ex_ready  out  1  accept-this-cycle; low = stall upstream.
REQ-008 SHALL have port flush  in  1  exception/eret/syscall squash; clears link state.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_be out 4, mem_addr out AW, mem_wdata out 32, mem_ack in 1, mem_rdata in 32: data-memory bus.
REQ-010 SHALL have ports wb_valid out 1, wb_wr out 1, wb_addr out 5, wb_data out 32: writeback.
REQ-011 SHALL have ports exc_adel out 1, exc_ades out 1, exc_bus out 1: one-cycle exception pulses.

Function
REQ-012 SHALL decode ex_op: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011, LL 110000, SC 111000; all others pass-through.
REQ-013 SHALL implement FSM IDLE/WAIT; ex_ready = (state==IDLE).
REQ-014 SHALL, in IDLE with ex_valid and pass-through op, register wb_valid=1, wb_wr=ex_regwr, wb_addr=ex_rd, wb_data=ex_result next cycle (latency 1, one per cycle).
REQ-015 SHALL, in IDLE with ex_valid and aligned memory op, latch op/addr/data/rd and enter WAIT; mem_req, mem_we, mem_be, mem_addr, mem_wdata are registered and stable throughout WAIT.
REQ-016 SHALL hold mem_req high in WAIT until mem_ack; on ack return to IDLE and produce wb_valid the following cycle; mem_ack outside WAIT ignored.
REQ-017 SHALL check alignment: halfword ops need addr[0]=0; LW/SW/LL/SC need addr[1:0]=0; violation pulses exc_adel (loads/LL) or exc_ades (stores/SC) next cycle, no bus access, wb_valid=0, stays IDLE.
REQ-018 SHALL select lane k = addr[1:0] (BIG_END=0) or 3-addr[1:0] (BIG_END=1); halfword lane pair from addr[1] likewise.
REQ-019 SHALL sign-extend LB/LH and zero-extend LBU/LHU from mem_rdata; LW/LL return mem_rdata unchanged.
REQ-020 SHALL drive stores: SB be one-hot lane k, byte replicated x4; SH be 0011 or 1100, halfword replicated x2; SW/SC be 1111.
REQ-021 SHALL count WAIT cycles; after TIMEOUT cycles without ack, drop mem_req, pulse exc_bus, no writeback, return IDLE.
REQ-022 SHALL keep llbit and lladdr (AW-2 word address); LL completion sets llbit=1, lladdr=addr[AW-1:2].
REQ-023 SHALL treat SC as success iff llbit=1 and lladdr matches; success issues write, wb_data=1 after ack, clears llbit.
REQ-024 SHALL, on SC fail, skip bus access, next cycle wb_valid=1, wb_wr=1, wb_addr=ex_rd, wb_data=0.
REQ-025 SHALL clear llbit when SW/SH/SB to lladdr word completes.
REQ-026 SHALL, on flush: clear llbit; in IDLE discard current input; in WAIT drop mem_req next cycle, return IDLE, suppress wb and exceptions.
REQ-027 SHALL give flush priority over simultaneous LL completion (llbit ends 0) and over ack.

Reset
REQ-028 SHALL, on rst low, immediately force state=IDLE, llbit=0, lladdr=0, timeout count=0, every output 0 except ex_ready=1.
REQ-029 SHALL abandon any in-flight access on reset mid-WAIT; no writeback after release.

Verification
REQ-030 SHALL cover LB addr 0x1003, mem_rdata 0x80FF_1234, BIG_END=0 -> wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-031 SHALL cover SH addr 0x2002 wdata 0x0000_BEEF -> mem_be 1100, mem_wdata 0xBEEF_BEEF, wb_valid 0.
REQ-032 SHALL cover LL 0x40 then SC 0x40 -> write issued, wb_data 1; second SC 0x40 -> no mem_req, wb_data 0.
REQ-033 SHALL cover LW addr 0x0006 -> exc_adel one cycle, mem_req never high, wb_valid 0.
REQ-034 SHALL cover LW with mem_ack withheld, TIMEOUT=4 -> mem_req 4 cycles, exc_bus pulse, ex_ready high next cycle.
REQ-035 SHALL cover flush asserted in WAIT after LL -> mem_req low next cycle, llbit 0, no wb_valid.

Source files
------------

// File: rtl/mem_ctrl.sv
// Load/store unit between the EX stage and a single-beat data-memory bus.
// Handles lane steering, sign/zero extension, LL/SC link state, bus timeout and flush.
module mem_ctrl #(
   parameter int AW      = 32,
   parameter int TIMEOUT = 16,
   parameter int BIG_END = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_valid,
   input  logic [5:0]    ex_op,
   input  logic [AW-1:0] ex_addr,
   input  logic [31:0]   ex_wdata,
   input  logic [31:0]   ex_result,
   input  logic [4:0]    ex_rd,
   input  logic          ex_regwr,
   output logic          ex_ready,
   input  logic          flush,
   output logic          mem_req,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic          wb_valid,
   output logic          wb_wr,
   output logic [4:0]    wb_addr,
   output logic [31:0]   wb_data,
   output logic          exc_adel,
   output logic          exc_ades,
   output logic          exc_bus,
   output logic          dbg_state,
   output logic          dbg_llbit
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_LL  = 6'b110000;
   localparam logic [5:0] OP_SC  = 6'b111000;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [3:0]      mem_be_q, mem_be_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [5:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            llbit_q, llbit_d;
   logic [AW-3:0]   lladdr_q, lladdr_d;
   logic            wb_valid_q, wb_valid_d, wb_wr_q, wb_wr_d;
   logic [4:0]      wb_addr_q, wb_addr_d;
   logic [31:0]     wb_data_q, wb_data_d;
   logic            exc_adel_q, exc_adel_d, exc_ades_q, exc_ades_d, exc_bus_q, exc_bus_d;

   logic            is_load, is_store, is_byte, is_half, is_word, misaligned, ll_match;
   logic [1:0]      in_lane, rd_lane;
   logic            in_hi, rd_hi;
   logic [3:0]      in_be;
   logic [31:0]     in_wdata, load_data;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;

   assign is_load  = ex_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL};
   assign is_store = ex_op inside {OP_SB, OP_SH, OP_SW, OP_SC};
   assign is_byte  = ex_op inside {OP_LB, OP_LBU, OP_SB};
   assign is_half  = ex_op inside {OP_LH, OP_LHU, OP_SH};
   assign is_word  = ex_op inside {OP_LW, OP_SW, OP_LL, OP_SC};
   assign misaligned = (is_half & ex_addr[0]) | (is_word & (|ex_addr[1:0]));
   assign ll_match = llbit_q && (lladdr_q == ex_addr[AW-1:2]);

   // Big-endian lane number is 3-addr[1:0], i.e. the bitwise inverse.
   assign in_lane = (BIG_END != 0) ? ~ex_addr[1:0] : ex_addr[1:0];
   assign in_hi   = ex_addr[1] ^ (BIG_END != 0);
   assign rd_lane = (BIG_END != 0) ? ~mem_addr_q[1:0] : mem_addr_q[1:0];
   assign rd_hi   = mem_addr_q[1] ^ (BIG_END != 0);

   always_comb begin
      in_be    = 4'b1111;
      in_wdata = ex_wdata;
      if (is_byte) begin
         in_be    = 4'b0001 << in_lane;
         in_wdata = {4{ex_wdata[7:0]}};
      end else if (is_half) begin
         in_be    = in_hi ? 4'b1100 : 4'b0011;
         in_wdata = {2{ex_wdata[15:0]}};
      end
   end

   always_comb begin
      rd_byte = mem_rdata[{rd_lane, 3'b000} +: 8];
      rd_half = rd_hi ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_q)
         OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  load_data = {24'd0, rd_byte};
         OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  load_data = {16'd0, rd_half};
         default: load_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      op_d        = op_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      llbit_d     = llbit_q;
      lladdr_d    = lladdr_q;
      wb_valid_d  = 1'b0;
      wb_wr_d     = wb_wr_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      exc_adel_d  = 1'b0;
      exc_ades_d  = 1'b0;
      exc_bus_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               llbit_d = 1'b0;
            end else if (ex_valid) begin
               if (!is_load && !is_store) begin
                  wb_valid_d = 1'b1;
                  wb_wr_d    = ex_regwr;
                  wb_addr_d  = ex_rd;
                  wb_data_d  = ex_result;
               end else if (misaligned) begin
                  exc_adel_d = is_load;
                  exc_ades_d = is_store;
               end else if ((ex_op == OP_SC) && !ll_match) begin
                  wb_valid_d = 1'b1;
                  wb_wr_d    = 1'b1;
                  wb_addr_d  = ex_rd;
                  wb_data_d  = 32'd0;
               end else begin
                  state_d     = S_WAIT;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_be_d    = in_be;
                  mem_addr_d  = ex_addr;
                  mem_wdata_d = in_wdata;
                  op_d        = ex_op;
                  rd_d        = ex_rd;
                  cnt_d       = 8'd0;
                  // A successful SC consumes the link as soon as it is committed to the bus.
                  if (ex_op == OP_SC)
                     llbit_d = 1'b0;
               end
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               llbit_d   = 1'b0;
            end else if (mem_ack) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  wb_valid_d = 1'b1;
                  wb_wr_d    = 1'b1;
                  wb_addr_d  = rd_q;
                  wb_data_d  = load_data;
               end else if (op_q == OP_SC) begin
                  wb_valid_d = 1'b1;
                  wb_wr_d    = 1'b1;
                  wb_addr_d  = rd_q;
                  wb_data_d  = 32'd1;
               end else if (lladdr_q == mem_addr_q[AW-1:2]) begin
                  llbit_d = 1'b0;
               end
               if (op_q == OP_LL) begin
                  llbit_d  = 1'b1;
                  lladdr_d = mem_addr_q[AW-1:2];
               end
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               exc_bus_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         op_q        <= 6'd0;
         rd_q        <= 5'd0;
         cnt_q       <= 8'd0;
         llbit_q     <= 1'b0;
         lladdr_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_wr_q     <= 1'b0;
         wb_addr_q   <= 5'd0;
         wb_data_q   <= 32'd0;
         exc_adel_q  <= 1'b0;
         exc_ades_q  <= 1'b0;
         exc_bus_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         llbit_q     <= llbit_d;
         lladdr_q    <= lladdr_d;
         wb_valid_q  <= wb_valid_d;
         wb_wr_q     <= wb_wr_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         exc_adel_q  <= exc_adel_d;
         exc_ades_q  <= exc_ades_d;
         exc_bus_q   <= exc_bus_d;
      end
   end

   // ex_valid/ex_ready: an instruction is taken on a rising edge where both are high;
   // the EX stage must hold its fields stable while ex_ready is low.
   assign ex_ready  = (state_q == S_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_valid  = wb_valid_q;
   assign wb_wr     = wb_wr_q;
   assign wb_addr   = wb_addr_q;
   assign wb_data   = wb_data_q;
   assign exc_adel  = exc_adel_q;
   assign exc_ades  = exc_ades_q;
   assign exc_bus   = exc_bus_q;
   assign dbg_state = (state_q == S_WAIT);
   assign dbg_llbit = llbit_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed cases for the named scenarios, then random transactions
// checked against a transaction-level model of lane steering, extension and LL/SC link state.
module tb_mem_ctrl;

   localparam int AW      = 16;
   localparam int TIMEOUT = 4;
   localparam int BIG_END = 0;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_LL  = 6'b110000;
   localparam logic [5:0] OP_SC  = 6'b111000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ex_valid = 1'b0;
   logic [5:0]    ex_op = '0;
   logic [AW-1:0] ex_addr = '0;
   logic [31:0]   ex_wdata = '0, ex_result = '0;
   logic [4:0]    ex_rd = '0;
   logic          ex_regwr = 1'b0;
   logic          ex_ready;
   logic          flush = 1'b0;
   logic          mem_req, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic          wb_valid, wb_wr;
   logic [4:0]    wb_addr;
   logic [31:0]   wb_data;
   logic          exc_adel, exc_ades, exc_bus, dbg_state, dbg_llbit;

   int            n_vec = 0;
   int            n_miss = 0;
   logic          m_llbit = 1'b0;
   logic [AW-3:0] m_lladdr = '0;
   logic [5:0]    op_tab [10] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_LL, OP_SC};

   mem_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT), .BIG_END(BIG_END)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
      .ex_wdata(ex_wdata), .ex_result(ex_result), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
      .ex_ready(ex_ready), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
      .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_addr(wb_addr),
      .wb_data(wb_data), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
      .dbg_state(dbg_state), .dbg_llbit(dbg_llbit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lane_of(input logic [AW-1:0] a);
      int k;
      k = int'(a[1:0]);
      return (BIG_END != 0) ? 3 - k : k;
   endfunction

   function automatic int half_of(input logic [AW-1:0] a);
      int h;
      h = int'(a[1]);
      return (BIG_END != 0) ? 1 - h : h;
   endfunction

   function automatic int size_of(input logic [5:0] op);
      if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
      if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [AW-1:0] a);
      if (size_of(op) == 1) return 4'(1 << lane_of(a));
      if (size_of(op) == 2) return 4'(3 << (2 * half_of(a)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [5:0] op, input logic [31:0] wd);
      if (size_of(op) == 1) return (wd & 32'hFF) * 32'h0101_0101;
      if (size_of(op) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [AW-1:0] a,
                                            input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * lane_of(a))) & 32'hFF;
      h = (rd >> (16 * half_of(a))) & 32'hFFFF;
      case (op)
         OP_LB:   return (b >= 32'd128) ? b - 32'd256 : b;
         OP_LBU:  return b;
         OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
         OP_LHU:  return h;
         default: return rd;
      endcase
   endfunction

   // One EX-stage transaction; ack_dly >= TIMEOUT means the bus never acknowledges.
   task automatic run_txn(input logic [5:0] op, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] result, input logic [4:0] rd, input logic regwr,
                          input int ack_dly, input logic [31:0] rdata);
      logic is_ld, is_st, mis, sc_ok, done;
      is_ld = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL};
      is_st = op inside {OP_SB, OP_SH, OP_SW, OP_SC};
      mis   = (is_ld || is_st) && ((int'(addr) % size_of(op)) != 0);
      sc_ok = m_llbit && (m_lladdr == AW'(addr >> 2));
      done  = 1'b0;
      check("ready_before", ex_ready, 1);
      ex_op = op; ex_addr = addr; ex_wdata = wdata; ex_result = result;
      ex_rd = rd; ex_regwr = regwr; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      if (!is_ld && !is_st) begin
         check("pt_valid", wb_valid, 1);
         check("pt_wr", wb_wr, regwr);
         check("pt_addr", wb_addr, rd);
         check("pt_data", wb_data, result);
         check("pt_req", mem_req, 0);
      end else if (mis) begin
         check("mis_adel", exc_adel, is_ld);
         check("mis_ades", exc_ades, is_st);
         check("mis_wb", wb_valid, 0);
         check("mis_req", mem_req, 0);
         check("mis_ready", ex_ready, 1);
      end else if (op == OP_SC && !sc_ok) begin
         check("scf_valid", wb_valid, 1);
         check("scf_wr", wb_wr, 1);
         check("scf_addr", wb_addr, rd);
         check("scf_data", wb_data, 0);
         check("scf_req", mem_req, 0);
      end else begin
         if (op == OP_SC) m_llbit = 1'b0;
         for (int i = 0; i < TIMEOUT && !done; i++) begin
            check("acc_req", mem_req, 1);
            check("acc_we", mem_we, is_st);
            check("acc_be", mem_be, exp_be(op, addr));
            check("acc_addr", mem_addr, addr);
            if (is_st) check("acc_wdata", mem_wdata, exp_wd(op, wdata));
            check("acc_ready", ex_ready, 0);
            if (i == ack_dly) begin
               mem_ack = 1'b1; mem_rdata = rdata;
            end else begin
               mem_rdata = $urandom;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (i == ack_dly) begin
               done = 1'b1;
               check("ack_req", mem_req, 0);
               check("ack_ready", ex_ready, 1);
               check("ack_wbv", wb_valid, is_ld || op == OP_SC);
               if (is_ld) begin
                  check("ld_wr", wb_wr, 1);
                  check("ld_addr", wb_addr, rd);
                  check("ld_data", wb_data, exp_load(op, addr, rdata));
               end
               if (op == OP_SC) begin
                  check("sc_addr", wb_addr, rd);
                  check("sc_data", wb_data, 1);
               end
               if (op == OP_LL) begin
                  m_llbit = 1'b1; m_lladdr = AW'(addr >> 2);
               end else if (is_st && m_lladdr == AW'(addr >> 2)) begin
                  m_llbit = 1'b0;
               end
               check("llbit", dbg_llbit, m_llbit);
            end else if (i == TIMEOUT - 1) begin
               check("to_bus", exc_bus, 1);
               check("to_req", mem_req, 0);
               check("to_ready", ex_ready, 1);
               check("to_wb", wb_valid, 0);
            end
         end
      end
      @(posedge clk); #1;
      check("quiet_wb", wb_valid, 0);
      check("quiet_exc", {exc_adel, exc_ades, exc_bus}, 0);
   endtask

   initial begin
      int dly;
      logic [5:0] op;
      logic [AW-1:0] addr;
      #3;
      check("rst_ready", ex_ready, 1);
      check("rst_req", mem_req, 0);
      check("rst_be", mem_be, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wb", {wb_valid, wb_wr, wb_addr}, 0);
      check("rst_wbdata", wb_data, 0);
      check("rst_exc", {exc_adel, exc_ades, exc_bus}, 0);
      check("rst_state", dbg_state, 0);
      check("rst_llbit", dbg_llbit, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      run_txn(OP_LB,  16'h1003, 0, 0, 5'd3, 1, 1, 32'h80FF_1234);
      run_txn(OP_LBU, 16'h1003, 0, 0, 5'd4, 1, 0, 32'h80FF_1234);
      run_txn(OP_SH,  16'h2002, 32'h0000_BEEF, 0, 5'd0, 0, 2, 0);
      run_txn(OP_LL,  16'h0040, 0, 0, 5'd7, 1, 0, 32'h1234_5678);
      run_txn(OP_SC,  16'h0040, 32'hCAFE_0001, 0, 5'd8, 1, 1, 0);
      run_txn(OP_SC,  16'h0040, 32'hCAFE_0002, 0, 5'd9, 1, 0, 0);
      run_txn(OP_LW,  16'h0006, 0, 0, 5'd1, 1, 0, 0);
      run_txn(OP_LW,  16'h0100, 0, 0, 5'd2, 1, TIMEOUT, 0);
      run_txn(OP_SC,  16'h0041, 0, 0, 5'd2, 1, 0, 0);
      run_txn(OP_LH,  16'h0003, 0, 0, 5'd2, 1, 0, 0);
      run_txn(OP_LHU, 16'h0012, 0, 0, 5'd5, 1, 3, 32'h9ABC_1234);
      run_txn(OP_LH,  16'h0012, 0, 0, 5'd6, 1, 0, 32'h9ABC_1234);
      run_txn(OP_SB,  16'h0011, 32'h0000_00A5, 0, 5'd0, 0, 0, 0);
      mem_ack = 1'b1;
      run_txn(6'b000000, 16'h0000, 0, 32'hDEAD_BEEF, 5'd31, 1, 0, 0);
      mem_ack = 1'b0;

      // Store to the linked word breaks the link.
      run_txn(OP_LL, 16'h0080, 0, 0, 5'd7, 1, 0, 32'h0);
      run_txn(OP_SW, 16'h0080, 32'h1111_2222, 0, 5'd0, 0, 1, 0);
      run_txn(OP_SC, 16'h0080, 32'h3, 0, 5'd10, 1, 0, 0);

      // Flush in WAIT after LL, with a simultaneous ack that must lose.
      run_txn(OP_LL, 16'h0040, 0, 0, 5'd7, 1, 0, 32'h0);
      ex_op = OP_LL; ex_addr = 16'h0040; ex_rd = 5'd11; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      check("fl_req_hi", mem_req, 1);
      flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      flush = 1'b0; mem_ack = 1'b0; m_llbit = 1'b0;
      check("fl_req_lo", mem_req, 0);
      check("fl_llbit", dbg_llbit, 0);
      check("fl_wb", wb_valid, 0);
      check("fl_ready", ex_ready, 1);
      check("fl_exc", {exc_adel, exc_ades, exc_bus}, 0);
      @(posedge clk); #1;
      check("fl_wb_late", wb_valid, 0);

      // Flush in IDLE discards the offered instruction and clears the link.
      run_txn(OP_LL, 16'h0090, 0, 0, 5'd7, 1, 0, 32'h0);
      ex_op = 6'b000001; ex_result = 32'h7777; ex_rd = 5'd12; ex_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0; flush = 1'b0; m_llbit = 1'b0;
      check("fli_wb", wb_valid, 0);
      check("fli_llbit", dbg_llbit, 0);

      // Reset in the middle of a WAIT abandons the access.
      run_txn(OP_LL, 16'h00A0, 0, 0, 5'd7, 1, 0, 32'h0);
      ex_op = OP_LW; ex_addr = 16'h0100; ex_rd = 5'd13; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      check("rw_req_hi", mem_req, 1);
      rst = 1'b0; mem_ack = 1'b1;
      #1;
      m_llbit = 1'b0; m_lladdr = '0;
      check("rw_req", mem_req, 0);
      check("rw_ready", ex_ready, 1);
      check("rw_state", dbg_state, 0);
      check("rw_llbit", dbg_llbit, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("rw_wb", wb_valid, 0);
      check("rw_req2", mem_req, 0);

      for (int n = 0; n < 200; n++) begin
         op   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 9)];
         addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(16'h40, 16'h47))
                                            : AW'($urandom_range(0, 255));
         dly  = $urandom_range(0, TIMEOUT);
         run_txn(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), dly, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
